// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential cache reads, tracks in-flight
// requests, buffers returned instructions and handles redirects.
// Optional build macro IFU_FETCH_STATS_EN adds fetch/discard statistic counters.
module ifu_prefetch #(
   parameter int                ADDR_W    = 32,
   parameter int                CACHE_AW  = 25,
   parameter int                DEPTH     = 4,
   parameter int                MAX_OUTST = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                jtag_reset_i,
   input  logic                jump_flag_i,
   input  logic [ADDR_W-1:0]   jump_addr_i,
   output logic [31:0]         inst_o,
   output logic [ADDR_W-1:0]   inst_addr_o,
   output logic                inst_valid_o,
   input  logic                inst_ready_i,
   output logic [CACHE_AW-1:0] o_p_addr,
   output logic                o_p_read,
   output logic                o_p_write,
   output logic [3:0]          o_p_byte_en,
   output logic [31:0]         o_p_writedata,
   input  logic [31:0]         i_p_readdata,
   input  logic                i_p_readdata_valid,
   input  logic                i_p_waitrequest
`ifdef IFU_FETCH_STATS_EN
   ,
   output logic [31:0]         stat_fetched_o,
   output logic [31:0]         stat_discarded_o
`endif
);

   localparam int BW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int PAW = CACHE_AW - 2;
   localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] OUTST_LIM = CW'(MAX_OUTST);
   localparam logic [PW-1:0] PF_LAST   = PW'(MAX_OUTST - 1);

   logic [ADDR_W-1:0] pc;
   logic [CW-1:0]     count;
   logic [CW-1:0]     outst;
   logic [CW-1:0]     discard;
   logic [BW-1:0]     wr_ptr;
   logic [BW-1:0]     rd_ptr;
   logic [PW-1:0]     pf_wr;
   logic [PW-1:0]     pf_rd;
   logic [31:0]       buf_data [DEPTH];
   logic [ADDR_W-1:0] buf_addr [DEPTH];
   logic [ADDR_W-1:0] pf_mem   [MAX_OUTST];
   logic [CW:0]       used;
   logic              any_rst;
   logic              accept;
   logic              retire;
   logic              drop;
   logic              push;
   logic              pop;

   function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] p);
      return (p == PF_LAST) ? '0 : p + 1'b1;
   endfunction

   assign any_rst = rst | jtag_reset_i;

   // Credit counts both buffered entries and every in-flight read (including
   // ones already marked for discard), so a push can never find the buffer full.
   assign used     = {1'b0, count} + {1'b0, outst};
   assign o_p_read = !any_rst && !jump_flag_i && (outst < OUTST_LIM) && (used < DEPTH_LIM);
   assign o_p_addr = CACHE_AW'(pc[PAW-1:0]);
   assign accept   = o_p_read && !i_p_waitrequest;

   // Responses with nothing outstanding (e.g. after reset) are ignored.
   assign retire = i_p_readdata_valid && (outst != '0);
   assign drop   = retire && ((discard != '0) || jump_flag_i);
   assign push   = retire && !drop;
   assign pop    = (count != '0) && inst_ready_i;

   assign inst_valid_o = (count != '0);
   assign inst_o       = inst_valid_o ? buf_data[rd_ptr] : '0;
   assign inst_addr_o  = inst_valid_o ? buf_addr[rd_ptr] : '0;

   assign o_p_write     = 1'b0;
   assign o_p_byte_en   = '0;
   assign o_p_writedata = '0;

   // Fetch PC, request tracking, discard accounting and buffer pointers.
   always_ff @(posedge clk) begin
      if (any_rst) begin
         pc      <= RESET_PC;
         outst   <= '0;
         discard <= '0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pf_wr   <= '0;
         pf_rd   <= '0;
      end else begin
         // Stale requests stay counted in outst until their responses retire;
         // discard marks how many of the oldest ones must be thrown away.
         outst <= outst + CW'(accept) - CW'(retire);
         if (accept) pf_wr <= pf_next(pf_wr);
         if (retire) pf_rd <= pf_next(pf_rd);
         if (jump_flag_i) begin
            pc      <= jump_addr_i;
            discard <= outst - CW'(retire);
            count   <= '0;
            rd_ptr  <= wr_ptr;
         end else begin
            if (accept) pc <= pc + 1'b1;
            if (retire && (discard != '0)) discard <= discard - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Remember the PC of each accepted request for pairing with its response.
   always_ff @(posedge clk) begin
      if (accept) pf_mem[pf_wr] <= pc;
   end

   // Store accepted instruction data alongside its request PC.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= i_p_readdata;
         buf_addr[wr_ptr] <= pf_mem[pf_rd];
      end
   end

`ifdef IFU_FETCH_STATS_EN
   // Wrapping counters of buffered and discarded responses.
   always_ff @(posedge clk) begin
      if (any_rst) begin
         stat_fetched_o   <= '0;
         stat_discarded_o <= '0;
      end else begin
         if (push) stat_fetched_o   <= stat_fetched_o + 1'b1;
         if (drop) stat_discarded_o <= stat_discarded_o + 1'b1;
      end
   end
`endif

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in instruction words.
REQ-002 SHALL have parameter CACHE_AW, default 25, cache address width; o_p_addr = zero-extended pc[CACHE_AW-3:0].
REQ-003 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_OUTST, default 2, maximum in-flight cache reads (1..DEPTH).
REQ-005 SHALL have parameter RESET_PC, default 0, PC after reset.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high); jtag_reset_i in 1 debug reset, same effect as rst.
REQ-007 SHALL have ports: jump_flag_i in 1 redirect request; jump_addr_i in ADDR_W redirect target.
REQ-008 SHALL have ports: inst_o out 32 instruction; inst_addr_o out ADDR_W its PC; inst_valid_o out 1; inst_ready_i in 1 decoder accept.
REQ-009 SHALL have ports: o_p_addr out CACHE_AW; o_p_read out 1; o_p_write out 1; o_p_byte_en out 4; o_p_writedata out 32; i_p_readdata in 32; i_p_readdata_valid in 1; i_p_waitrequest in 1.

Function
REQ-010 SHALL tie o_p_write=0, o_p_byte_en=0, o_p_writedata=0.
REQ-011 SHALL define a request as accepted in a cycle where o_p_read=1 and i_p_waitrequest=0; o_p_addr SHALL remain stable while o_p_read=1 and i_p_waitrequest=1.
REQ-012 SHALL assert o_p_read only when outstanding<MAX_OUTST, buffer_count+outstanding<DEPTH, no jump_flag_i and not in reset.
REQ-013 SHALL increment fetch PC by 1 (modulo 2^ADDR_W, wrap to 0) per accepted request.
REQ-014 SHALL assume in-order cache responses; each i_p_readdata_valid retires the oldest outstanding request.
REQ-015 SHALL push non-discarded responses into the buffer with their request PC (per-request PC FIFO of MAX_OUTST entries).
REQ-016 SHALL present buffer head on inst_o/inst_addr_o with inst_valid_o=1 when non-empty; pop on inst_valid_o & inst_ready_i; first data visible one cycle after i_p_readdata_valid.
REQ-017 SHALL support simultaneous push and pop; the credit rule of REQ-012 SHALL make overflow impossible; pop when empty SHALL be ignored.
REQ-018 On jump_flag_i: buffer flushed, inst_valid_o=0 next cycle, fetch PC=jump_addr_i, discard counter loaded with outstanding requests not retired that cycle.
REQ-019 Responses arriving while discard counter>0 SHALL decrement it and SHALL NOT enter the buffer.
REQ-020 First request to jump_addr_i SHALL issue no earlier than the cycle after jump_flag_i; jump during a waitrequest stall SHALL abandon the stalled request (not counted outstanding).
REQ-021 Back-to-back jumps: last jump wins; discard count accumulates correctly.

Reset
REQ-022 rst or jtag_reset_i SHALL set fetch PC=RESET_PC, outstanding=0, discard=0, buffer empty, inst_o=0, inst_addr_o=0, inst_valid_o=0, o_p_read=0.
REQ-023 Reset mid-operation SHALL drop all in-flight requests; responses arriving after reset release with outstanding=0 SHALL be ignored.

Configuration
REQ-024 With IFU_FETCH_STATS_EN defined, SHALL add outputs stat_fetched_o (32) counting buffer pushes and stat_discarded_o (32) counting discarded responses, both wrapping, cleared by reset.
REQ-025 Without IFU_FETCH_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-026 Reset, cache 1-cycle latency, inst_ready_i=1 -> addresses 0,1,2,3 issued back-to-back, inst_addr_o sequence 0,1,2,3.
REQ-027 inst_ready_i=0 with DEPTH=4 -> exactly 4 pushes then o_p_read=0; ready released -> fetch resumes, no lost or duplicated PC.
REQ-028 i_p_waitrequest=1 for 3 cycles at PC=5 -> o_p_addr held at 5, single request accepted.
REQ-029 Two outstanding (PC 8,9), jump_flag_i to 0x40 -> both responses discarded, next inst_addr_o=0x40, stat_discarded_o=2 if enabled.
REQ-030 Fetch at PC 0x7FFFFF with CACHE_AW=25 -> next o_p_addr=0; ADDR_W PC wraps from all-ones to 0.
REQ-031 jtag_reset_i with 2 outstanding -> outputs zero, late responses ignored, fetch restarts at RESET_PC.
